// File: rtl/round_sched.sv
`default_nettype none
// ============================================================================
// Module  : round_sched
// Brief   : Round-robin, packet-locked arbiter that feeds NUM_CH AXI-stream
//           requesters into one rounding stage (WIDTH_IN -> WIDTH_OUT bits).
//           Optional clip statistics are enabled by ROUND_SCHED_CLIP_STATS_EN.
// Revision: 1.0
// ============================================================================
module round_sched #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16,
  parameter int CH_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef ROUND_SCHED_CLIP_STATS_EN
  input  logic                       clip_clear,
  output logic [NUM_CH*16-1:0]       clip_count,
`endif
  input  logic [NUM_CH*WIDTH_IN-1:0] i_tdata,
  input  logic [NUM_CH-1:0]          i_tlast,
  input  logic [NUM_CH-1:0]          i_tvalid,
  output logic [NUM_CH-1:0]          i_tready,
  input  logic [2*NUM_CH-1:0]        i_mode,
  output logic [WIDTH_OUT-1:0]       o_tdata,
  output logic [CH_W-1:0]            o_tuser,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready
);

  localparam int D = WIDTH_IN - WIDTH_OUT;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      ptr_q, ptr_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;
  logic [1:0]           cur_mode_q, cur_mode_d;
  logic                 bubble_q, bubble_d;
  logic [WIDTH_OUT-1:0] o_tdata_q, o_tdata_d;
  logic [CH_W-1:0]      o_tuser_q, o_tuser_d;
  logic                 o_tlast_q, o_tlast_d;
  logic                 o_tvalid_q, o_tvalid_d;

  logic                 out_free;
  logic                 arb_found;
  logic [CH_W-1:0]      arb_ch;
  logic [CH_W:0]        arb_sum;
  logic                 gnt_act;
  logic [CH_W-1:0]      gnt_ch;
  logic [1:0]           gnt_mode;
  logic                 accept;
  logic                 beat_last;
  logic [WIDTH_IN-1:0]  x;
  logic                 guard_hit;
  logic                 corr;
  logic [WIDTH_OUT-1:0] rounded;

  assign out_free = !o_tvalid_q || o_tready;

  // First valid channel at or above the pointer, wrapping past NUM_CH-1.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (arb_sum >= (CH_W+1)'(NUM_CH)) begin
        arb_sum = arb_sum - (CH_W+1)'(NUM_CH);
      end
      if (!arb_found && i_tvalid[arb_sum[CH_W-1:0]]) begin
        arb_found = 1'b1;
        arb_ch    = arb_sum[CH_W-1:0];
      end
    end
  end

  // IDLE grants combinationally so the first beat can go through immediately;
  // the bubble flag blocks a grant in the cycle right after a release.
  always_comb begin
    gnt_act  = 1'b0;
    gnt_ch   = cur_ch_q;
    gnt_mode = cur_mode_q;
    if (state_q == S_LOCKED) begin
      gnt_act = 1'b1;
    end else if (!bubble_q && arb_found) begin
      gnt_act  = 1'b1;
      gnt_ch   = arb_ch;
      gnt_mode = i_mode[arb_ch*2 +: 2];
    end
  end

  always_comb begin
    i_tready = '0;
    if (gnt_act && out_free && !reset) begin
      i_tready[gnt_ch] = 1'b1;
    end
  end

  assign accept    = |(i_tready & i_tvalid);
  assign beat_last = i_tlast[gnt_ch];
  assign x         = i_tdata[gnt_ch*WIDTH_IN +: WIDTH_IN];

  always_comb begin
    guard_hit = 1'b0;
    if (D > 1) begin
      guard_hit = !x[WIDTH_IN-1] && (&x[WIDTH_IN-2:D]);
    end
    case (gnt_mode)
      2'd0:    corr = x[D-1] && !guard_hit;
      2'd1:    corr = x[WIDTH_IN-1] && (|x[D-1:0]);
      default: corr = 1'b0;
    endcase
    rounded = x[WIDTH_IN-1:D] + WIDTH_OUT'(corr);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_ch_d   = cur_ch_q;
    cur_mode_d = cur_mode_q;
    bubble_d   = bubble_q;
    o_tdata_d  = o_tdata_q;
    o_tuser_d  = o_tuser_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q;

    if (state_q == S_IDLE) begin
      bubble_d = 1'b0;
      if (gnt_act) begin
        state_d    = S_LOCKED;
        cur_ch_d   = gnt_ch;
        cur_mode_d = gnt_mode;
      end
    end

    if (accept && beat_last) begin
      state_d  = S_IDLE;
      bubble_d = 1'b1;
      ptr_d    = (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + 1'b1;
    end

    if (accept) begin
      o_tdata_d  = rounded;
      o_tuser_d  = gnt_ch;
      o_tlast_d  = beat_last;
      o_tvalid_d = 1'b1;
    end else if (o_tready) begin
      o_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cur_ch_q   <= '0;
      cur_mode_q <= '0;
      bubble_q   <= 1'b0;
      o_tdata_q  <= '0;
      o_tuser_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_ch_q   <= cur_ch_d;
      cur_mode_q <= cur_mode_d;
      bubble_q   <= bubble_d;
      o_tdata_q  <= o_tdata_d;
      o_tuser_q  <= o_tuser_d;
      o_tlast_q  <= o_tlast_d;
      o_tvalid_q <= o_tvalid_d;
    end
  end

  assign o_tdata  = o_tdata_q;
  assign o_tuser  = o_tuser_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;

`ifdef ROUND_SCHED_CLIP_STATS_EN
  // A clip is a nearest-mode beat whose round-up was suppressed by the guard.
  logic        clip_hit;
  logic [15:0] clip_q [NUM_CH];
  logic [15:0] clip_d [NUM_CH];

  assign clip_hit = accept && (gnt_mode == 2'd0) && x[D-1] && guard_hit;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      clip_d[c] = clip_q[c];
      if (clip_clear) begin
        clip_d[c] = '0;
      end else if (clip_hit && (gnt_ch == CH_W'(c)) && (clip_q[c] != 16'hFFFF)) begin
        clip_d[c] = clip_q[c] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        clip_q[c] <= '0;
      end else begin
        clip_q[c] <= clip_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_clip_out
    assign clip_count[g*16 +: 16] = clip_q[g];
  end
`endif

endmodule
`default_nettype wire
